blake_req_arb: RTL and testbench



---
 rtl/blake_arb_pkg.sv | 23 ++
 rtl/blake_req_arb_rr_pick.sv | 37 +++
 rtl/blake_req_arb.sv | 156 +++++++++++++++
 tb/tb_blake_req_arb.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/blake_arb_pkg.sv
// Shared types and helpers for the BLAKE2 requester arbiter.
package blake_arb_pkg;

  localparam int N_MAX = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_STREAM,
    S_FIN,
    S_DRAIN
  } arb_state_e;

  function automatic logic [2:0] onehot_to_idx(input logic [N_MAX-1:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < N_MAX; i++) begin
      if (oh[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/blake_req_arb_rr_pick.sv
// Combinational round-robin picker: first requester at or after rr_ptr, wrapping.
module rr_pick
  import blake_arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  input  logic [2:0]   rr_ptr,
  output logic [N-1:0] grant,
  output logic [2:0]   idx
);

  logic [N_MAX-1:0] grant_ext;
  logic             found;

  // Upper pass covers [rr_ptr, N-1]; lower pass wraps around to [0, rr_ptr-1].
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && req[i] && (3'(i) >= rr_ptr)) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!found && req[i]) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
    grant_ext         = '0;
    grant_ext[N-1:0]  = grant;
    idx               = onehot_to_idx(grant_ext);
  end

endmodule

// File: rtl/blake_req_arb.sv
// Round-robin, per-message arbiter sharing one BLAKE2 engine among N byte-stream
// requesters, with a finish-to-digest watchdog.
module blake_req_arb
  import blake_arb_pkg::*;
#(
  parameter int N        = 4,
  parameter int W        = 32,
  parameter int WAIT_MAX = 1024
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [8*N-1:0] req_data,
  input  logic [N-1:0]   req_dv,
  input  logic [N-1:0]   req_fin,
  output logic [N-1:0]   gnt,
  output logic [N-1:0]   req_rdy,
  output logic [7:0]     rsp_data,
  output logic [N-1:0]   rsp_dv,
  output logic [N-1:0]   rsp_end,
  output logic           err,
  output logic           eng_start,
  output logic [7:0]     eng_data,
  output logic           eng_dv,
  output logic           eng_finish,
  input  logic           eng_drdy,
  input  logic [7:0]     eng_dout,
  input  logic           eng_dvout,
  input  logic           eng_dend
);

  localparam int WD_W = $clog2(WAIT_MAX) + 1;
  localparam int BC_W = $clog2(W + 1) + 1;

  arb_state_e      state, state_n;
  logic [N-1:0]    gnt_n;
  logic [2:0]      owner, owner_n;
  logic [2:0]      rr_ptr, rr_ptr_n;
  logic [2:0]      next_ptr;
  logic [WD_W-1:0] wd_cnt, wd_cnt_n;
  logic [BC_W-1:0] byte_cnt, byte_cnt_n;
  logic [N-1:0]    pick_gnt;
  logic [2:0]      pick_idx;
  logic [7:0]      own_byte;
  logic            own_dv;
  logic            own_fin;

  rr_pick #(.N(N)) u_pick (
    .req    (req),
    .rr_ptr (rr_ptr),
    .grant  (pick_gnt),
    .idx    (pick_idx)
  );

  assign next_ptr = (owner == 3'(N - 1)) ? 3'd0 : owner + 3'd1;

  always_comb begin
    own_byte = '0;
    own_dv   = 1'b0;
    own_fin  = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (gnt[i]) begin
        own_byte = req_data[8*i +: 8];
        own_dv   = req_dv[i];
        own_fin  = req_fin[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      gnt      <= '0;
      owner    <= '0;
      rr_ptr   <= '0;
      wd_cnt   <= '0;
      byte_cnt <= '0;
    end else begin
      state    <= state_n;
      gnt      <= gnt_n;
      owner    <= owner_n;
      rr_ptr   <= rr_ptr_n;
      wd_cnt   <= wd_cnt_n;
      byte_cnt <= byte_cnt_n;
    end
  end

  always_comb begin
    state_n    = state;
    gnt_n      = gnt;
    owner_n    = owner;
    rr_ptr_n   = rr_ptr;
    wd_cnt_n   = wd_cnt;
    byte_cnt_n = byte_cnt;
    req_rdy    = '0;
    rsp_data   = '0;
    rsp_dv     = '0;
    rsp_end    = '0;
    err        = 1'b0;
    eng_start  = 1'b0;
    eng_data   = '0;
    eng_dv     = 1'b0;
    eng_finish = 1'b0;

    case (state)
      S_IDLE: begin
        if (|req) begin
          gnt_n   = pick_gnt;
          owner_n = pick_idx;
          state_n = S_START;
        end
      end
      S_START: begin
        eng_start = 1'b1;
        state_n   = S_STREAM;
      end
      S_STREAM: begin
        req_rdy    = gnt & {N{eng_drdy}};
        eng_data   = own_byte;
        eng_dv     = own_dv & eng_drdy;
        wd_cnt_n   = '0;
        byte_cnt_n = '0;
        if (own_fin) begin
          eng_finish = 1'b1;
          state_n    = S_FIN;
        end
      end
      S_FIN, S_DRAIN: begin
        eng_finish = 1'b1;
        // The first digest byte is forwarded in the same cycle it leaves S_FIN.
        if (state == S_DRAIN || eng_dvout) begin
          rsp_data   = eng_dout;
          rsp_dv     = eng_dvout ? gnt : '0;
          rsp_end    = eng_dend ? gnt : '0;
          byte_cnt_n = byte_cnt + BC_W'(eng_dvout);
          state_n    = S_DRAIN;
          if (eng_dend) begin
            err      = (byte_cnt_n != BC_W'(W));
            state_n  = S_IDLE;
            gnt_n    = '0;
            rr_ptr_n = next_ptr;
          end
        end else if (wd_cnt == WD_W'(WAIT_MAX - 1)) begin
          err      = 1'b1;
          state_n  = S_IDLE;
          gnt_n    = '0;
          rr_ptr_n = next_ptr;
        end else begin
          wd_cnt_n = wd_cnt + WD_W'(1);
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_blake_req_arb.sv
// Scoreboard bench for blake_req_arb: an engine model in the bench supplies digests.
module tb_blake_req_arb;

  localparam int N        = 4;
  localparam int W        = 32;
  localparam int WAIT_MAX = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_r, dv_r, fin_r;
  logic [8*N-1:0] data_r;
  logic [N-1:0]   noise_dv   = '0;
  logic [N-1:0]   noise_fin  = '0;
  logic [8*N-1:0] noise_data = '0;
  logic [N-1:0]   req, req_dv, req_fin;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   gnt, req_rdy, rsp_dv, rsp_end;
  logic [7:0]     rsp_data, eng_data, eng_dout;
  logic           err, eng_start, eng_dv, eng_finish;
  logic           eng_drdy, eng_dvout, eng_dend;
  bit             noise_en = 1'b0;

  int vectors     = 0;
  int miscompares = 0;
  int start_cnt   = 0;

  typedef struct packed {logic [7:0] b; logic fin;} eng_exp_t;
  typedef struct packed {logic [N-1:0] oh; logic [7:0] b; logic last;} rsp_exp_t;
  eng_exp_t eng_q[$];
  rsp_exp_t rsp_q[$];
  eng_exp_t ee;
  rsp_exp_t re;

  assign req      = req_r;
  assign req_dv   = dv_r | noise_dv;
  assign req_fin  = fin_r | noise_fin;
  assign req_data = data_r | noise_data;

  blake_req_arb #(.N(N), .W(W), .WAIT_MAX(WAIT_MAX)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_data   (req_data),
    .req_dv     (req_dv),
    .req_fin    (req_fin),
    .gnt        (gnt),
    .req_rdy    (req_rdy),
    .rsp_data   (rsp_data),
    .rsp_dv     (rsp_dv),
    .rsp_end    (rsp_end),
    .err        (err),
    .eng_start  (eng_start),
    .eng_data   (eng_data),
    .eng_dv     (eng_dv),
    .eng_finish (eng_finish),
    .eng_drdy   (eng_drdy),
    .eng_dout   (eng_dout),
    .eng_dvout  (eng_dvout),
    .eng_dend   (eng_dend)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  // Requester 2 chatters on its byte lane while idle; none of it may reach the engine.
  always @(posedge clk) begin
    #1;
    noise_dv   = '0;
    noise_fin  = '0;
    noise_data = '0;
    if (noise_en) begin
      noise_dv[2]          = 1'($urandom);
      noise_fin[2]         = 1'($urandom);
      noise_data[23:16]    = 8'($urandom);
    end
  end

  always @(negedge clk) begin
    if (eng_start) begin
      start_cnt++;
      checkOutput("start_fin_low", 32'(eng_finish), 32'd0);
    end
    if (eng_dv) begin
      if (eng_q.size() == 0) checkOutput("eng_dv_unexp", 32'd1, 32'd0);
      else begin
        ee = eng_q.pop_front();
        checkOutput("eng_data", 32'(eng_data), 32'(ee.b));
        checkOutput("eng_fin", 32'(eng_finish), 32'(ee.fin));
        checkOutput("req_rdy", 32'(req_rdy), 32'(gnt));
      end
    end
    if (rsp_dv != '0 || rsp_end != '0) begin
      if (rsp_q.size() == 0) checkOutput("rsp_unexp", 32'(rsp_dv), 32'd0);
      else begin
        re = rsp_q.pop_front();
        checkOutput("rsp_dv", 32'(rsp_dv), 32'(re.oh));
        checkOutput("rsp_data", 32'(rsp_data), 32'(re.b));
        checkOutput("rsp_end", 32'(rsp_end), re.last ? 32'(re.oh) : 32'd0);
      end
    end
  end

  task automatic applyReset();
    rst       = 1'b1;
    req_r     = '0;
    dv_r      = '0;
    fin_r     = '0;
    data_r    = '0;
    eng_drdy  = 1'b1;
    eng_dvout = 1'b0;
    eng_dend  = 1'b0;
    eng_dout  = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset_ctl", 32'({gnt, req_rdy, rsp_dv, rsp_end, err, eng_start, eng_dv, eng_finish}), 32'd0);
    checkOutput("reset_data", 32'({rsp_data, eng_data}), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    eng_q.delete();
    rsp_q.delete();
  endtask

  task automatic waitGrant(input int who);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (gnt == '0 && k < 10);
    checkOutput("gnt_owner", 32'(gnt), 32'(1 << who));
    checkOutput("gnt_start", 32'(eng_start), 32'd1);
  endtask

  task automatic applyStimulus(input int who, input int len, input logic [31:0] msg, input bit coincide);
    for (int i = 0; i < len; i++) begin
      @(posedge clk);
      #1;
      data_r[8*who +: 8] = msg[8*i +: 8];
      dv_r[who]  = 1'b1;
      fin_r[who] = coincide && (i == len - 1);
      eng_q.push_back('{b: msg[8*i +: 8], fin: coincide && (i == len - 1)});
    end
    if (!(coincide && len > 0)) begin
      @(posedge clk);
      #1;
      dv_r[who]  = 1'b0;
      fin_r[who] = 1'b1;
    end
    @(negedge clk);
    checkOutput("fin_comb", 32'(eng_finish), 32'd1);
    @(posedge clk);
    #1;
    dv_r[who]  = 1'b0;
    fin_r[who] = 1'b0;
    data_r     = '0;
  endtask

  task automatic driveDigest(input int who, input logic [7:0] seed, input int n, input int delay);
    repeat (delay) begin
      @(negedge clk);
      checkOutput("fin_hold", 32'(eng_finish), 32'd1);
      @(posedge clk);
      #1;
    end
    for (int k = 0; k < n; k++) begin
      eng_dvout = 1'b1;
      eng_dout  = seed + 8'(k);
      eng_dend  = (k == n - 1);
      rsp_q.push_back('{oh: N'(1 << who), b: seed + 8'(k), last: (k == n - 1)});
      if (k == n - 1) begin
        @(negedge clk);
        checkOutput("drain_err", 32'(err), 32'(n != W));
      end
      @(posedge clk);
      #1;
    end
    eng_dvout = 1'b0;
    eng_dend  = 1'b0;
    eng_dout  = '0;
    @(negedge clk);
    checkOutput("gnt_release", 32'(gnt), 32'd0);
    checkOutput("fin_release", 32'(eng_finish), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL sim_timeout: got still running, want finished");
    $fatal(1);
  end

  initial begin
    int s0;
    int first_err;
    int err_pulses;

    // Single requester, "abc" with finish on the last byte.
    applyReset();
    s0 = start_cnt;
    req_r = 4'b0001;
    waitGrant(0);
    applyStimulus(0, 3, 32'h00636261, 1'b1);
    driveDigest(0, 8'h10, W, 3);
    req_r = '0;
    checkOutput("start_pulses", 32'(start_cnt - s0), 32'd1);

    // All four requesting continuously.
    applyReset();
    req_r = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      waitGrant(i % N);
      applyStimulus(i % N, 1, 32'(8'h30 + 8'(i)), 1'b1);
      driveDigest(i % N, 8'(i * 16), W, 1);
    end
    req_r = '0;

    // Wrap-around from rr_ptr=2 with only requesters 0 and 1 active.
    applyReset();
    req_r = 4'b0010;
    waitGrant(1);
    applyStimulus(1, 2, 32'h0000aa55, 1'b0);
    driveDigest(1, 8'h20, W, 2);
    req_r = 4'b0011;
    waitGrant(0);
    applyStimulus(0, 1, 32'h000000e1, 1'b1);
    driveDigest(0, 8'h40, W, 1);
    req_r[0] = 1'b0;
    waitGrant(1);
    applyStimulus(1, 1, 32'h000000e2, 1'b1);
    driveDigest(1, 8'h60, W, 1);
    req_r = '0;

    // Silent engine: watchdog fires, then the pointer moves on to requester 3.
    req_r = 4'b0100;
    waitGrant(2);
    applyStimulus(2, 1, 32'h00000041, 1'b1);
    first_err  = 0;
    err_pulses = 0;
    for (int k = 1; k <= WAIT_MAX; k++) begin
      @(negedge clk);
      if (err) begin
        err_pulses++;
        if (first_err == 0) first_err = k;
      end
      if (k == WAIT_MAX) req_r[3] = 1'b1;
    end
    checkOutput("wd_err_cycle", first_err, WAIT_MAX);
    @(negedge clk);
    if (err) err_pulses++;
    checkOutput("wd_err_pulses", err_pulses, 1);
    checkOutput("wd_idle", 32'({gnt, eng_finish}), 32'd0);
    waitGrant(3);
    applyStimulus(3, 2, 32'h00007a79, 1'b1);
    driveDigest(3, 8'h80, W, 2);
    req_r[3] = 1'b0;

    // Zero-length message plus a short digest from requester 2.
    waitGrant(2);
    applyStimulus(2, 0, 32'h0, 1'b1);
    driveDigest(2, 8'ha0, W - 1, 2);
    req_r = '0;

    // Asynchronous reset with a byte in flight, then a clean restart.
    applyReset();
    req_r = 4'b0001;
    waitGrant(0);
    @(posedge clk);
    #1;
    data_r[7:0] = 8'h5a;
    dv_r[0]     = 1'b1;
    #1 checkOutput("inflight_dv", 32'(eng_dv), 32'd1);
    #1 rst = 1'b1;
    #1;
    checkOutput("rst_async_ctl", 32'({gnt, req_rdy, rsp_dv, rsp_end, err, eng_start, eng_dv, eng_finish}), 32'd0);
    checkOutput("rst_async_data", 32'({rsp_data, eng_data}), 32'd0);
    dv_r   = '0;
    data_r = '0;
    @(posedge clk);
    #1 rst = 1'b0;
    s0 = start_cnt;
    waitGrant(0);
    applyStimulus(0, 2, 32'h00006968, 1'b0);
    driveDigest(0, 8'h90, W, 1);
    req_r = '0;
    checkOutput("restart_start", 32'(start_cnt - s0), 32'd1);

    // Requester 1 streams while requester 2 chatters without requesting.
    noise_en = 1'b1;
    req_r = 4'b0010;
    waitGrant(1);
    applyStimulus(1, 4, 32'h44332211, 1'b1);
    driveDigest(1, 8'hc0, W, 2);
    req_r = '0;
    noise_en = 1'b0;
    repeat (2) @(negedge clk);

    checkOutput("eng_q_left", eng_q.size(), 0);
    checkOutput("rsp_q_left", rsp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
